// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning channel selector.
// Holds the FSM state encoding, the mode constants and the dwell-counter width rule.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A single-cycle dwell still needs a 1-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int dwell);
        return (dwell <= 1) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control, channel bank and presented-output bundle for the scanning selector.
// Master drives controls and channel data; slave (the sequencer) drives the outputs.
interface mux_scan_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 32
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          manual_sel;
    logic                      hold;
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      scan_wrap;
    logic                      sel_err;

    modport master (
        output en, mode, manual_sel, hold, in_bus,
        input  out_data, out_sel, out_valid, scan_wrap, sel_err
    );

    modport slave (
        input  en, mode, manual_sel, hold, in_bus,
        output out_data, out_sel, out_valid, scan_wrap, sel_err
    );

endinterface

// File: rtl/mux_nto1_comb.sv
// Combinational WIDTH x CHANNELS selector; unmatched select values yield zero.
// Latency: 0 clocks; no backpressure.
module mux_nto1_comb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 32,
    parameter int SEL_W    = 5
) (
    input  logic [CHANNELS*WIDTH-1:0] i_bus,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_dat
);

    always_comb begin
        o_dat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_dat = i_bus[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Registered N-channel selector with manual select and round-robin scan with dwell/hold.
// Latency: 1 clock from select/data change to outputs; no backpressure (consumer always accepts).
module mux_scan_sequencer
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 32,
    parameter int DWELL    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_scan_sequencer_if.slave  bus
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam int CW    = cnt_width(DWELL);

    localparam logic [SEL_W:0]   LP_CH       = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LP_LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [CW-1:0]    LP_LAST_CNT = CW'(DWELL - 1);

    state_t           r_state;
    state_t           w_nstate;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_ncnt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_nsel;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_mux_dat;
    logic             r_valid;
    logic             r_wrap;
    logic             r_err;
    logic             w_wrap;
    logic             w_err;

    mux_nto1_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .i_bus (bus.in_bus),
        .i_sel (w_nsel),
        .o_dat (w_mux_dat)
    );

    always_comb begin
        w_nstate = !bus.en ? IDLE : ((bus.mode == MODE_SCAN) ? SCAN : MANUAL);
        w_nsel   = r_sel;
        w_ncnt   = '0;
        w_wrap   = 1'b0;
        w_err    = 1'b0;
        case (w_nstate)
            MANUAL: begin
                if ({1'b0, bus.manual_sel} < LP_CH) begin
                    w_nsel = bus.manual_sel;
                end else begin
                    w_err = 1'b1;
                end
            end
            SCAN: begin
                // Entering scan always restarts from channel 0 with a fresh dwell.
                if (r_state != SCAN) begin
                    w_nsel = '0;
                end else if (bus.hold) begin
                    w_ncnt = r_cnt;
                end else if (r_cnt == LP_LAST_CNT) begin
                    if (r_sel == LP_LAST_CH) begin
                        w_nsel = '0;
                        w_wrap = 1'b1;
                    end else begin
                        w_nsel = r_sel + SEL_W'(1);
                    end
                end else begin
                    w_ncnt = r_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_sel   <= w_nsel;
            r_valid <= (w_nstate != IDLE);
            r_wrap  <= w_wrap;
            r_err   <= w_err;
            // In IDLE the last presented sample is frozen rather than resampled.
            if (w_nstate != IDLE) begin
                r_data <= w_mux_dat;
            end
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;
    assign bus.out_valid = r_valid;
    assign bus.scan_wrap = r_wrap;
    assign bus.sel_err   = r_err;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for the scanning selector: a 32-channel and a 5-channel instance share one clock.
// Expected outputs are queued when a step is driven and compared one clock later.
module tb_mux_scan_sequencer;

    logic clk;
    logic reset;

    mux_scan_sequencer_if #(.WIDTH(8), .CHANNELS(32)) ifa ();
    mux_scan_sequencer_if #(.WIDTH(8), .CHANNELS(5))  ifb ();

    mux_scan_sequencer #(.WIDTH(8), .CHANNELS(32), .DWELL(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    mux_scan_sequencer #(.WIDTH(8), .CHANNELS(5), .DWELL(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] sel;
        logic       valid;
        logic       wrap;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic obs_t mk(input int d, input int s, input bit v, input bit w, input bit e);
        obs_t o;
        o.data  = 8'(d);
        o.sel   = 5'(s);
        o.valid = v;
        o.wrap  = w;
        o.err   = e;
        return o;
    endfunction

    task automatic step(input string tag, input bit dut_b, input obs_t expv);
        obs_t got;
        obs_t want;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (dut_b)
            got = {ifb.out_data, 2'b00, ifb.out_sel, ifb.out_valid, ifb.scan_wrap, ifb.sel_err};
        else
            got = {ifa.out_data, ifa.out_sel, ifa.out_valid, ifa.scan_wrap, ifa.sel_err};
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ifa.en         = 1'b1;
        ifa.mode       = 1'b1;
        ifa.hold       = 1'b0;
        ifa.manual_sel = '0;
        ifb.en         = 1'b1;
        ifb.mode       = 1'b1;
        ifb.hold       = 1'b0;
        ifb.manual_sel = '0;
        for (int k = 0; k < 32; k++) ifa.in_bus[k*8 +: 8] = 8'hA0 + 8'(k);
        for (int k = 0; k < 5; k++)  ifb.in_bus[k*8 +: 8] = 8'h50 + 8'(k);

        step("reset_a0", 1'b0, mk(0, 0, 0, 0, 0));
        step("reset_a1", 1'b0, mk(0, 0, 0, 0, 0));
        step("reset_b",  1'b1, mk(0, 0, 0, 0, 0));
        reset  = 1'b0;
        ifa.en = 1'b0;
        ifb.en = 1'b0;
        step("idle_a0", 1'b0, mk(0, 0, 0, 0, 0));
        step("idle_a1", 1'b0, mk(0, 0, 0, 0, 0));

        // Manual select on the 32-channel instance.
        ifa.en = 1'b1; ifa.mode = 1'b0; ifa.manual_sel = 5'd7;
        step("man_sel7", 1'b0, mk(8'hA7, 7, 1, 0, 0));
        ifa.manual_sel = 5'd31; ifa.hold = 1'b1;
        step("man_sel31", 1'b0, mk(8'hBF, 31, 1, 0, 0));
        ifa.in_bus[31*8 +: 8] = 8'h3C;
        step("man_live", 1'b0, mk(8'h3C, 31, 1, 0, 0));
        ifa.in_bus[31*8 +: 8] = 8'hBF; ifa.hold = 1'b0;
        step("man_restore", 1'b0, mk(8'hBF, 31, 1, 0, 0));
        ifa.en = 1'b0;
        step("man_to_idle", 1'b0, mk(8'hBF, 31, 0, 0, 0));

        // Out-of-range manual select on the 5-channel instance.
        ifb.en = 1'b1; ifb.mode = 1'b0; ifb.manual_sel = 3'd3;
        step("oor_sel3", 1'b1, mk(8'h53, 3, 1, 0, 0));
        ifb.manual_sel = 3'd6;
        step("oor_sel6", 1'b1, mk(8'h53, 3, 1, 0, 1));
        ifb.manual_sel = 3'd4;
        step("oor_sel4", 1'b1, mk(8'h54, 4, 1, 0, 0));
        ifb.manual_sel = 3'd7;
        step("oor_sel7", 1'b1, mk(8'h54, 4, 1, 0, 1));
        ifb.manual_sel = 3'd0;
        step("oor_sel0", 1'b1, mk(8'h50, 0, 1, 0, 0));

        // Scan of the 5-channel instance, wrap after 20 cycles.
        ifb.mode = 1'b1;
        for (int c = 0; c < 20; c++) step("scan_b", 1'b1, mk(8'h50 + c/4, c/4, 1, 0, 0));
        step("wrap_b", 1'b1, mk(8'h50, 0, 1, 1, 0));
        ifb.en = 1'b0;
        step("b_idle", 1'b1, mk(8'h50, 0, 0, 0, 0));

        // Full scan of the 32-channel instance from IDLE.
        ifa.en = 1'b1; ifa.mode = 1'b1;
        for (int c = 0; c < 128; c++) step("scan_a", 1'b0, mk(8'hA0 + c/4, c/4, 1, 0, 0));
        step("wrap_a", 1'b0, mk(8'hA0, 0, 1, 1, 0));
        for (int c = 1; c <= 22; c++) step("scan_a2", 1'b0, mk(8'hA0 + c/4, c/4, 1, 0, 0));

        // Now at channel 5 with count 2: freeze and watch live data.
        ifa.hold = 1'b1; ifa.in_bus[5*8 +: 8] = 8'h11;
        for (int c = 0; c < 5; c++) step("hold_11", 1'b0, mk(8'h11, 5, 1, 0, 0));
        ifa.in_bus[5*8 +: 8] = 8'h22;
        for (int c = 0; c < 5; c++) step("hold_22", 1'b0, mk(8'h22, 5, 1, 0, 0));
        ifa.hold = 1'b0;
        step("resume_1", 1'b0, mk(8'h22, 5, 1, 0, 0));
        step("resume_2", 1'b0, mk(8'hA6, 6, 1, 0, 0));
        ifa.in_bus[5*8 +: 8] = 8'hA5;
        for (int c = 1; c <= 12; c++) step("scan_a3", 1'b0, mk(8'hA0 + 6 + c/4, 6 + c/4, 1, 0, 0));

        // Drop enable at channel 9, then re-enable.
        ifa.en = 1'b0;
        step("drop_en0", 1'b0, mk(8'hA9, 9, 0, 0, 0));
        step("drop_en1", 1'b0, mk(8'hA9, 9, 0, 0, 0));
        ifa.en = 1'b1;
        step("reenable", 1'b0, mk(8'hA0, 0, 1, 0, 0));
        for (int c = 1; c <= 48; c++) step("scan_a4", 1'b0, mk(8'hA0 + c/4, c/4, 1, 0, 0));

        // Reset mid-scan at channel 12.
        reset = 1'b1;
        step("mid_reset", 1'b0, mk(0, 0, 0, 0, 0));
        reset = 1'b0; ifa.en = 1'b0;
        step("post_reset", 1'b0, mk(0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
